uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit path downstream of the UART register block.
- Accepts bytes written to the TX data register (one-cycle write strobe plus a byte) and buffers them in a FIFO.
- Serialises each byte onto uart_tx as 8N1/8N2 frames, with the bit period taken from the clock-divider register.
- Reports FIFO level and busy status so the register block can expose them for software polling.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, 4..256.
- DIV_MIN, 4, minimum bit period in clk cycles; smaller clk_div values are clamped to this.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- clk_div  in  32  bit period in clk cycles (from clock-divider register).
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- wr_valid  in  1  one-cycle strobe: push wr_data.
- wr_data  in  8  byte to transmit.
- wr_ready  out  1  FIFO not full (registered).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held.
- busy  out  1  frame in progress or FIFO non-empty.
- uart_tx  out  1  serial line, idle high, registered.

Behaviour:
- Reset (resetn low at a clk edge):
  - uart_tx=1, wr_ready=1, fifo_level=0, busy=0, state IDLE.
  - FIFO pointers cleared; bit counter and divider counter cleared.
  - Reset mid-frame aborts the frame: uart_tx is 1 from the next edge.
- FIFO push:
  - Occurs on an edge with wr_valid && wr_ready.
  - wr_valid while full is dropped silently; level and contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- wr_ready: registered; deasserts on the edge where level reaches FIFO_DEPTH and reasserts on the edge after a pop from full.
- Simultaneous push and pop: level unchanged, both take effect. A push is never accepted while full, even if a pop happens on the same edge.
- Divider:
  - At frame start, latch period P = max(clk_div[15:0], DIV_MIN); clk_div[31:16] is ignored.
  - Each bit lasts exactly P clk cycles.
  - Changes to clk_div mid-frame take effect at the next frame.
- State machine: IDLE -> START -> DATA -> STOP -> (START | IDLE).
  - IDLE: uart_tx=1. If the FIFO is non-empty, the next edge pops the head into the shift register, latches P and cfg_stop2, drives uart_tx=0 and enters START.
  - START: P cycles at 0, then DATA.
  - DATA: 8 bits, LSB first, P cycles each; a 3-bit counter wraps 7->0, then STOP.
  - STOP: 1 for P cycles (2P if the latched stop2=1). At the end, if the FIFO is non-empty, pop and enter START on the same edge (no idle gap); otherwise IDLE.
- Latency: a byte written into an empty FIFO while IDLE at edge N gives a start bit beginning at edge N+1. Frame length is 10P cycles (11P with stop2).
- busy = (state != IDLE) || (fifo_level != 0), registered with the state.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - Adds ports cfg_parity_en (in, 1) and cfg_parity_odd (in, 1), both latched at frame start.
  - When enabled, a PARITY state of P cycles is inserted between DATA and STOP. The parity bit is the XOR of the data bits, inverted when odd.
  - Frame length is 11P (12P with stop2).
- Not defined: those ports and the PARITY state do not exist; frames are always 8N1/8N2.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - DIV_MIN default;
  - divider width constant (16);
  - register offsets used by the register block for the TX data, status and level fields.
- One natural sub-module: uart_tx_fifo, a synchronous single-clock FIFO with push/pop/full/empty/level in distributed RAM.
  - The FIFO is reused later for the receive path.

Test Plan:
- Reset mid-frame:
  - Stimulus: clk_div=4, write 0x55, assert resetn low during DATA bit 3.
  - Expected: uart_tx=1 from the next edge, fifo_level=0, busy=0, no further transitions.
- Single byte, 8N1:
  - Stimulus: resetn released, clk_div=4, write 0xA5 at edge N.
  - Expected: uart_tx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high. Total 40 cycles; busy drops at N+41.
- Clamp and two stop bits:
  - Stimulus: clk_div=1, cfg_stop2=1, write 0x00.
  - Expected: P=4; 36 cycles low (start plus data), then 8 cycles high. Frame is 44 cycles.
- Back-to-back and full:
  - Stimulus: FIFO_DEPTH=16, clk_div=8; write 18 bytes 0x00..0x11 on consecutive cycles.
  - Expected: one byte is popped immediately, so 0x00..0x10 (17 bytes) are accepted. wr_ready falls after the 17th accepted write and 0x11 is dropped.
  - Expected: 17 frames with no idle gap between stop and start; fifo_level decrements once per 80 cycles.
- Simultaneous push/pop:
  - Stimulus: push on the same edge the STOP->START pop happens, with level=3.
  - Expected: level stays 3.
- Parity (UART_TX_PARITY_EN):
  - Stimulus: cfg_parity_en=1, cfg_parity_odd=0, write 0x07.
  - Expected: parity bit 1, frame 11P. With cfg_parity_odd=1 the parity bit is 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, divider sizing and the register map
// offsets the register block uses for the TX data, status and level fields.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned DIV_MIN_DEFAULT = 4;
  localparam int unsigned DIV_W           = 16;

  localparam logic [7:0] REG_TX_DATA  = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_TX_LEVEL = 8'h08;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO in distributed RAM with registered full/empty/level flags.
// Shared by the transmit path and, later, the receive path.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data_c,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses pushes even when a pop lands on the same edge.
  assign push_ok     = push && !full;
  assign pop_ok      = pop && !empty;
  assign level_nxt_c = level + LW'(push_ok) - LW'(pop_ok);
  assign pop_data_c  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(DEPTH));
      empty <= (level_nxt_c == '0);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: buffers written bytes and serialises them as 8N1/8N2 frames.
// Defining UART_TX_PARITY_EN adds an even/odd parity bit between data and stop.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_MIN    = DIV_MIN_DEFAULT
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [31:0]                 clk_div,
  input  logic                        cfg_stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
`endif
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        uart_tx
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_MIN_W = DIV_W'(DIV_MIN);

  tx_state_t        state, state_n;
  logic [DIV_W-1:0] period, period_n, cnt, cnt_n, div_clamped;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shreg, shreg_n, fifo_data;
  logic             stop2, stop2_n, tx_n, busy_n;
  logic             pop, load, tick;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    level_nxt;
  logic             unused_div_hi;
`ifdef UART_TX_PARITY_EN
  logic             par_en, par_en_n, par_bit, par_bit_n;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push        (wr_valid),
    .push_data   (wr_data),
    .pop         (pop),
    .pop_data_c  (fifo_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (fifo_level),
    .level_nxt_c (level_nxt)
  );

  assign wr_ready      = !fifo_full;
  assign unused_div_hi = ^clk_div[31:DIV_W];
  assign div_clamped   = (clk_div[DIV_W-1:0] < DIV_MIN_W) ? DIV_MIN_W : clk_div[DIV_W-1:0];
  assign tick          = (cnt == period - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      period  <= DIV_MIN_W;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      stop2   <= 1'b0;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en  <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      period  <= period_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      stop2   <= stop2_n;
      uart_tx <= tx_n;
      busy    <= busy_n;
`ifdef UART_TX_PARITY_EN
      par_en  <= par_en_n;
      par_bit <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    period_n = period;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    stop2_n  = stop2;
    tx_n     = uart_tx;
    pop      = 1'b0;
    load     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_n  = par_en;
    par_bit_n = par_bit;
`endif

    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        cnt_n = cnt + DIV_W'(1);
        if (tick) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_n = cnt + DIV_W'(1);
        if (tick) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en) begin
              tx_n    = par_bit;
              state_n = ST_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_STOP;
            end
`else
            tx_n    = 1'b1;
            state_n = ST_STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shreg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        cnt_n = cnt + DIV_W'(1);
        if (tick) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
          state_n = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        cnt_n = cnt + DIV_W'(1);
        if (tick) begin
          cnt_n = '0;
          // bit_idx counts the stop bits already sent when two are configured.
          if (stop2 && (bit_idx == 3'd0)) begin
            bit_n = 3'd1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase

    // Frame start: pop the head and latch all per-frame configuration.
    if (load) begin
      pop      = 1'b1;
      shreg_n  = fifo_data;
      period_n = div_clamped;
      stop2_n  = cfg_stop2;
      cnt_n    = '0;
      bit_n    = '0;
      tx_n     = 1'b0;
      state_n  = ST_START;
`ifdef UART_TX_PARITY_EN
      par_en_n  = cfg_parity_en;
      par_bit_n = (^fifo_data) ^ cfg_parity_odd;
`endif
    end

    busy_n = (state_n != ST_IDLE) || (level_nxt != '0);
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a queue-based model of the FIFO and serial line
// predicts every sampled cycle; scenarios also spot-check hand-derived timing points.
module tb_uart_tx_engine;

  localparam int FIFO_DEPTH = 16;
  localparam int LW  = 5;
  localparam int TXB = LW + 2;
  localparam int BSB = LW + 1;
  localparam int RDB = LW;

  typedef bit bq_t[$];

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   clk_div = 32'd4;
  logic          cfg_stop2 = 1'b0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          uart_tx;
`ifdef UART_TX_PARITY_EN
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]    mq[$];
  bq_t           line_q;
  logic [LW+2:0] act_q[$];
  logic [LW+2:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_engine #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_MIN(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .clk_div        (clk_div),
    .cfg_stop2      (cfg_stop2),
`ifdef UART_TX_PARITY_EN
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
`endif
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .fifo_level     (fifo_level),
    .busy           (busy),
    .uart_tx        (uart_tx)
  );

  function automatic int period_of(input logic [31:0] d);
    return (d[15:0] < 16'd4) ? 4 : int'(d[15:0]);
  endfunction

  // Expected line waveform of one frame, one entry per clk cycle.
  function automatic bq_t frame_bits(input logic [7:0] b);
    bq_t q;
    bit  bits[$];
    int  p = period_of(clk_div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    if (cfg_parity_en) bits.push_back((^b) ^ cfg_parity_odd);
`endif
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (p) q.push_back(bits[i]);
    return q;
  endfunction

  // Advance one clock; the model sees the same inputs as the DUT and both are traced.
  task automatic step();
    bit         do_pop, acc, in_frame, e_tx;
    logic [7:0] b;
    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      line_q.delete();
      in_frame = 1'b0;
      e_tx     = 1'b1;
    end else begin
      do_pop = (line_q.size() == 0) && (mq.size() != 0);
      acc    = wr_valid && (mq.size() < FIFO_DEPTH);
      if (do_pop) begin
        b      = mq.pop_front();
        line_q = frame_bits(b);
      end
      if (acc) mq.push_back(wr_data);
      in_frame = (line_q.size() != 0);
      e_tx     = in_frame ? line_q.pop_front() : 1'b1;
    end
    @(negedge clk);
    act_q.push_back({uart_tx, busy, wr_ready, fifo_level});
    exp_q.push_back({e_tx, (in_frame || mq.size() != 0), (mq.size() < FIFO_DEPTH), LW'(mq.size())});
  endtask

  task automatic clear_trace();
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int mis = -1;
    int low = 0;
    clk_div = 32'd4; cfg_stop2 = 1'b0;
    clear_trace();
    wr_data = 8'hA5; wr_valid = 1'b1; step(); wr_valid = 1'b0;
    repeat (45) step();
    foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
    checks++; if (mis >= 0) begin errors++; $display("FAIL single_trace idx %0d got %h want %h", mis, act_q[mis], exp_q[mis]); end
    for (int i = 1; i <= 40; i++) if (act_q[i][TXB] == 1'b0) low++;
    checks++; if (low != 20) begin errors++; $display("FAIL single_low_cycles got %0d want 20", low); end
    checks++; if (act_q[1][TXB] !== 1'b0) begin errors++; $display("FAIL single_start got %b want 0", act_q[1][TXB]); end
    checks++; if (act_q[5][TXB] !== 1'b1) begin errors++; $display("FAIL single_bit0 got %b want 1", act_q[5][TXB]); end
    checks++; if (act_q[40][BSB] !== 1'b1) begin errors++; $display("FAIL single_busy_n40 got %b want 1", act_q[40][BSB]); end
    checks++; if (act_q[41][BSB] !== 1'b0) begin errors++; $display("FAIL single_busy_n41 got %b want 0", act_q[41][BSB]); end
  endtask

  task automatic test_clamp_stop2();
    int mis = -1;
    int low = 0;
    clk_div = 32'h5A5A_0001; cfg_stop2 = 1'b1;
    clear_trace();
    wr_data = 8'h00; wr_valid = 1'b1; step(); wr_valid = 1'b0;
    repeat (50) step();
    foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
    checks++; if (mis >= 0) begin errors++; $display("FAIL clamp_trace idx %0d got %h want %h", mis, act_q[mis], exp_q[mis]); end
    for (int i = 1; i <= 44; i++) if (act_q[i][TXB] == 1'b0) low++;
    checks++; if (low != 36) begin errors++; $display("FAIL clamp_low_cycles got %0d want 36", low); end
    checks++; if (act_q[44][BSB] !== 1'b1) begin errors++; $display("FAIL clamp_busy_end got %b want 1", act_q[44][BSB]); end
    checks++; if (act_q[45][BSB] !== 1'b0) begin errors++; $display("FAIL clamp_busy_after got %b want 0", act_q[45][BSB]); end
    cfg_stop2 = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int         mis = -1;
      int         p;
      logic [7:0] b, dec;
      b = 8'($urandom);
      clk_div = {16'($urandom), 16'($urandom_range(0, 9))};
      cfg_stop2 = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
      cfg_parity_en  = 1'($urandom_range(0, 1));
      cfg_parity_odd = 1'($urandom_range(0, 1));
`endif
      p = period_of(clk_div);
      clear_trace();
      wr_data = b; wr_valid = 1'b1; step(); wr_valid = 1'b0;
      repeat (120) step();
      foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
      checks++; if (mis >= 0) begin errors++; $display("FAIL random_trace it %0d idx %0d got %h want %h", it, mis, act_q[mis], exp_q[mis]); end
      for (int k = 0; k < 8; k++) dec[k] = act_q[1 + (k + 1) * p + p / 2][TXB];
      checks++; if (dec !== b) begin errors++; $display("FAIL random_decode it %0d got %h want %h", it, dec, b); end
    end
    cfg_stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
`endif
  endtask

  task automatic test_back_to_back();
    int mis = -1;
    clk_div = 32'd8; cfg_stop2 = 1'b0;
    clear_trace();
    for (int i = 0; i < 1370; i++) begin
      wr_valid = (i < 18);
      wr_data  = 8'(i);
      step();
    end
    wr_valid = 1'b0;
    foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
    checks++; if (mis >= 0) begin errors++; $display("FAIL b2b_trace idx %0d got %h want %h", mis, act_q[mis], exp_q[mis]); end
    checks++; if (act_q[15][RDB] !== 1'b1) begin errors++; $display("FAIL b2b_ready_before_full got %b want 1", act_q[15][RDB]); end
    checks++; if (act_q[16][RDB] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", act_q[16][RDB]); end
    checks++; if (act_q[17][LW-1:0] !== LW'(16)) begin errors++; $display("FAIL b2b_level_drop got %0d want 16", act_q[17][LW-1:0]); end
    checks++; if (act_q[80][LW-1:0] !== LW'(16)) begin errors++; $display("FAIL b2b_level_n80 got %0d want 16", act_q[80][LW-1:0]); end
    checks++; if (act_q[81][LW-1:0] !== LW'(15)) begin errors++; $display("FAIL b2b_level_n81 got %0d want 15", act_q[81][LW-1:0]); end
    checks++; if (act_q[81][RDB] !== 1'b1) begin errors++; $display("FAIL b2b_ready_refill got %b want 1", act_q[81][RDB]); end
    checks++; if (act_q[80][TXB] !== 1'b1 || act_q[81][TXB] !== 1'b0) begin
      errors++; $display("FAIL b2b_no_gap got %b%b want 10", act_q[80][TXB], act_q[81][TXB]);
    end
    checks++; if (act_q[1361][BSB] !== 1'b0) begin errors++; $display("FAIL b2b_final_busy got %b want 0", act_q[1361][BSB]); end
  endtask

  task automatic test_simul_push_pop();
    int mis = -1;
    clk_div = 32'd4; cfg_stop2 = 1'b0;
    clear_trace();
    for (int i = 0; i < 300; i++) begin
      wr_valid = (i < 4) || (i == 41);
      wr_data  = 8'($urandom);
      if (i == 10) clk_div = 32'd6;
      step();
    end
    wr_valid = 1'b0;
    foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
    checks++; if (mis >= 0) begin errors++; $display("FAIL pushpop_trace idx %0d got %h want %h", mis, act_q[mis], exp_q[mis]); end
    checks++; if (act_q[40][LW-1:0] !== LW'(3)) begin errors++; $display("FAIL pushpop_level_before got %0d want 3", act_q[40][LW-1:0]); end
    checks++; if (act_q[41][LW-1:0] !== LW'(3)) begin errors++; $display("FAIL pushpop_level_same got %0d want 3", act_q[41][LW-1:0]); end
    checks++; if (act_q[41][TXB] !== 1'b0) begin errors++; $display("FAIL pushpop_restart got %b want 0", act_q[41][TXB]); end
  endtask

  task automatic test_reset_midframe();
    int mis = -1;
    int lows = 0;
    clk_div = 32'd4; cfg_stop2 = 1'b0;
    clear_trace();
    for (int i = 0; i < 80; i++) begin
      wr_valid = (i < 2);
      wr_data  = (i == 0) ? 8'h55 : 8'h33;
      resetn   = (i != 18);
      step();
    end
    resetn = 1'b1; wr_valid = 1'b0;
    foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
    checks++; if (mis >= 0) begin errors++; $display("FAIL rstmid_trace idx %0d got %h want %h", mis, act_q[mis], exp_q[mis]); end
    checks++; if (act_q[17][TXB] !== 1'b0) begin errors++; $display("FAIL rstmid_bit3 got %b want 0", act_q[17][TXB]); end
    checks++; if (act_q[18][TXB] !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", act_q[18][TXB]); end
    checks++; if (act_q[18][LW-1:0] !== '0) begin errors++; $display("FAIL rstmid_level got %0d want 0", act_q[18][LW-1:0]); end
    checks++; if (act_q[18][BSB] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", act_q[18][BSB]); end
    for (int i = 18; i < 80; i++) if (act_q[i][TXB] !== 1'b1) lows++;
    checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_quiet got %0d low cycles want 0", lows); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    for (int odd = 0; odd < 2; odd++) begin
      int mis = -1;
      clk_div = 32'd4; cfg_stop2 = 1'b0;
      cfg_parity_en = 1'b1; cfg_parity_odd = 1'(odd);
      clear_trace();
      wr_data = 8'h07; wr_valid = 1'b1; step(); wr_valid = 1'b0;
      repeat (50) step();
      foreach (act_q[i]) if (mis < 0 && act_q[i] !== exp_q[i]) mis = i;
      checks++; if (mis >= 0) begin errors++; $display("FAIL parity_trace odd %0d idx %0d got %h want %h", odd, mis, act_q[mis], exp_q[mis]); end
      checks++; if (act_q[37][TXB] !== 1'(odd == 0)) begin errors++; $display("FAIL parity_bit odd %0d got %b want %b", odd, act_q[37][TXB], odd == 0); end
      checks++; if (act_q[44][BSB] !== 1'b1 || act_q[45][BSB] !== 1'b0) begin
        errors++; $display("FAIL parity_len odd %0d busy got %b%b want 10", odd, act_q[44][BSB], act_q[45][BSB]);
      end
    end
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_clamp_stop2();
    test_random();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
